// File: rtl/divider_arbiter.sv
// Round-robin arbiter sharing one divider among NUM_REQ requesters, one divide in flight.
// Divide-by-zero and divider timeouts are answered locally so the shared divider never stalls.
module divider_arbiter #(
  parameter int unsigned NUM_REQ        = 3,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_dividend,
  input  logic [NUM_REQ*DATA_W-1:0] req_divisor,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_quotient,
  output logic                      rsp_div0,
  output logic                      rsp_timeout,
  output logic                      busy,
  output logic                      div_start,
  output logic [DATA_W-1:0]         div_dividend,
  output logic [DATA_W-1:0]         div_divisor,
  input  logic [DATA_W-1:0]         div_quotient,
  input  logic                      div_ready
);

  localparam int unsigned GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES) + 1;

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e              state_q, state_d;
  logic [GW-1:0]       grant_q, grant_d;
  logic [GW-1:0]       last_grant_q, last_grant_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [NUM_REQ-1:0]  req_ready_q, req_ready_d;
  logic [NUM_REQ-1:0]  rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_quotient_q, rsp_quotient_d;
  logic                rsp_div0_q, rsp_div0_d;
  logic                rsp_timeout_q, rsp_timeout_d;
  logic                busy_q, busy_d;
  logic                div_start_q, div_start_d;
  logic [DATA_W-1:0]   div_dividend_q, div_dividend_d;
  logic [DATA_W-1:0]   div_divisor_q, div_divisor_d;

  logic                found;
  logic [GW-1:0]       pick;
  logic [DATA_W-1:0]   sel_dividend, sel_divisor;

  // Round-robin: first requesting index strictly after the last served one, wrapping.
  always_comb begin
    int unsigned idx;
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      idx = (32'(last_grant_q) + i) % NUM_REQ;
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        pick  = idx[GW-1:0];
      end
    end
    sel_dividend = req_dividend[32'(pick)*DATA_W +: DATA_W];
    sel_divisor  = req_divisor[32'(pick)*DATA_W +: DATA_W];
  end

  always_comb begin
    state_d        = state_q;
    grant_d        = grant_q;
    last_grant_d   = last_grant_q;
    cnt_d          = cnt_q;
    req_ready_d    = '0;
    rsp_valid_d    = '0;
    rsp_quotient_d = rsp_quotient_q;
    rsp_div0_d     = 1'b0;
    rsp_timeout_d  = 1'b0;
    div_start_d    = 1'b0;
    div_dividend_d = div_dividend_q;
    div_divisor_d  = div_divisor_q;

    unique case (state_q)
      StIdle: begin
        if (found) begin
          grant_d           = pick;
          div_dividend_d    = sel_dividend;
          div_divisor_d     = sel_divisor;
          req_ready_d[pick] = 1'b1;
          div_start_d       = (sel_divisor != '0);
          state_d           = StIssue;
        end
      end
      StIssue: begin
        cnt_d = '0;
        if (div_divisor_q == '0) begin
          rsp_quotient_d       = '1;
          rsp_div0_d           = 1'b1;
          rsp_valid_d[grant_q] = 1'b1;
          state_d              = StResp;
        end else begin
          state_d = StWait;
        end
      end
      StWait: begin
        cnt_d = cnt_q + 1'b1;
        // A result on the final wait cycle still beats the timeout.
        if (div_ready) begin
          rsp_quotient_d       = div_quotient;
          rsp_valid_d[grant_q] = 1'b1;
          state_d              = StResp;
        end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          rsp_quotient_d       = '0;
          rsp_timeout_d        = 1'b1;
          rsp_valid_d[grant_q] = 1'b1;
          state_d              = StResp;
        end
      end
      StResp: begin
        last_grant_d = grant_q;
        state_d      = StIdle;
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      grant_q        <= '0;
      last_grant_q   <= GW'(NUM_REQ - 1);
      cnt_q          <= '0;
      req_ready_q    <= '0;
      rsp_valid_q    <= '0;
      rsp_quotient_q <= '0;
      rsp_div0_q     <= 1'b0;
      rsp_timeout_q  <= 1'b0;
      busy_q         <= 1'b0;
      div_start_q    <= 1'b0;
      div_dividend_q <= '0;
      div_divisor_q  <= '0;
    end else begin
      state_q        <= state_d;
      grant_q        <= grant_d;
      last_grant_q   <= last_grant_d;
      cnt_q          <= cnt_d;
      req_ready_q    <= req_ready_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_quotient_q <= rsp_quotient_d;
      rsp_div0_q     <= rsp_div0_d;
      rsp_timeout_q  <= rsp_timeout_d;
      busy_q         <= busy_d;
      div_start_q    <= div_start_d;
      div_dividend_q <= div_dividend_d;
      div_divisor_q  <= div_divisor_d;
    end
  end

  assign req_ready    = req_ready_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_quotient = rsp_quotient_q;
  assign rsp_div0     = rsp_div0_q;
  assign rsp_timeout  = rsp_timeout_q;
  assign busy         = busy_q;
  assign div_start    = div_start_q;
  assign div_dividend = div_dividend_q;
  assign div_divisor  = div_divisor_q;

endmodule
